// File: rtl/btn_input_ctrl.sv
// Push-button input controller: per-bit synchronizer and debounce, sticky press
// flags, press counter and a maskable level interrupt behind a 4-word register map.
module btn_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn,
  input  logic [1:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATE  = 2'd0;
  localparam logic [1:0] ADDR_EVENTS = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_CNT    = 2'd3;

  logic [4:0]  sync_meta_reg;
  logic [4:0]  sync_reg;
  logic [4:0]  stable;
  logic [4:0]  stable_d_reg;
  logic [4:0]  events_reg;
  logic [4:0]  events_next;
  logic [4:0]  mask_reg;
  logic [4:0]  mask_next;
  logic [4:0]  rise;
  logic [4:0]  clear;
  logic [2:0]  rise_count;
  logic [7:0]  cnt_reg;
  logic [7:0]  cnt_next;
  logic [31:0] read_value;
  logic        events_rd;
  logic        events_wr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_meta_reg <= '0;
      sync_reg      <= '0;
    end else begin
      sync_meta_reg <= btn;
      sync_reg      <= sync_meta_reg;
    end
  end

  // A bit must disagree with its accepted level for DEBOUNCE_CYCLES clocks in a row
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_debounce
      logic [15:0] count_reg;
      logic        stable_bit_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          count_reg      <= '0;
          stable_bit_reg <= 1'b0;
        end else if (sync_reg[gi] == stable_bit_reg) begin
          count_reg <= '0;
        end else if (count_reg == LAST_COUNT) begin
          stable_bit_reg <= sync_reg[gi];
          count_reg      <= '0;
        end else begin
          count_reg <= count_reg + 16'd1;
        end
      end

      assign stable[gi] = stable_bit_reg;
    end
  endgenerate

  always_comb begin
    rise       = stable & ~stable_d_reg;
    rise_count = '0;
    for (int i = 0; i < 5; i++) begin
      rise_count = rise_count + {2'b00, rise[i]};
    end
    cnt_next = cnt_reg + {5'b00000, rise_count};

    events_rd = rd_en && (addr == ADDR_EVENTS);
    events_wr = wr_en && (addr == ADDR_EVENTS);
    clear     = (events_rd ? events_reg : 5'b0) | (events_wr ? wdata[4:0] : 5'b0);
    // New rises are OR-ed in after the clear so a press is never lost to a clear
    events_next = (events_reg & ~clear) | rise;

    mask_next = (wr_en && (addr == ADDR_MASK)) ? wdata[4:0] : mask_reg;

    read_value = '0;
    case (addr)
      ADDR_STATE:  read_value = {27'b0, stable};
      ADDR_EVENTS: read_value = {27'b0, events_reg};
      ADDR_MASK:   read_value = {27'b0, mask_reg};
      ADDR_CNT:    read_value = {24'b0, cnt_reg};
      default:     read_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stable_d_reg <= '0;
      events_reg   <= '0;
      mask_reg     <= '0;
      cnt_reg      <= '0;
      rdata        <= '0;
      irq          <= 1'b0;
    end else begin
      stable_d_reg <= stable;
      events_reg   <= events_next;
      mask_reg     <= mask_next;
      cnt_reg      <= cnt_next;
      irq          <= |(events_next & mask_next);
      if (rd_en) begin
        rdata <= read_value;
      end
    end
  end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Directed testbench for btn_input_ctrl with DEBOUNCE_CYCLES=4; inputs change
// on the falling edge and outputs are sampled on the falling edge.
module tb_btn_input_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  btn;
  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors;
  int checks;

  btn_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .addr  (addr),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
    $display("rd addr=%0d data=0x%08h irq=%0b", a, d, irq);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    $display("wr addr=%0d data=0x%08h irq=%0b", a, d, irq);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0; btn = 5'h1F; addr = 2'd0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    idle(3);
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=0x%08h exp=0x00000000", rdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    rst = 1'b1;
    read_reg(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_state got=0x%08h exp=0x00000000", d); end
    btn = 5'h00;
    idle(20);
    read_reg(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_events got=0x%08h exp=0x00000000", d); end
  endtask

  task automatic test_clean_press();
    logic [31:0] d;
    btn = 5'h08;
    idle(5);
    // Read captured at edge 6 sees the pre-edge STATE; edge 7 sees the accepted level
    read_reg(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL press_state_early got=0x%08h exp=0x00000000", d); end
    read_reg(2'd0, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL press_state got=0x%08h exp=0x00000008", d); end
    idle(13);
    read_reg(2'd1, d);
    checks++;
    if (d !== 32'h8) begin errors++; $display("FAIL press_events got=0x%08h exp=0x00000008", d); end
    read_reg(2'd3, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL press_cnt got=0x%08h exp=0x00000001", d); end
    read_reg(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL press_events_cleared got=0x%08h exp=0x00000000", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_unmasked got=%0b exp=0", irq); end
    btn = 5'h00;
    idle(20);
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    btn = 5'h01;
    idle(3);
    btn = 5'h00;
    idle(20);
    read_reg(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_state got=0x%08h exp=0x00000000", d); end
    read_reg(2'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_events got=0x%08h exp=0x00000000", d); end
    read_reg(2'd3, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL glitch_cnt got=0x%08h exp=0x00000001", d); end
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    write_reg(2'd2, 32'h1);
    read_reg(2'd2, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL irq_mask_rb got=0x%08h exp=0x00000001", d); end
    btn = 5'h02;
    idle(20);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked_press got=%0b exp=0", irq); end
    btn = 5'h00;
    idle(20);
    btn = 5'h01;
    idle(20);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmasked_press got=%0b exp=1", irq); end
    btn = 5'h00;
    idle(10);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_level_hold got=%0b exp=1", irq); end
    write_reg(2'd1, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_w1c got=%0b exp=0", irq); end
    // events now 0x02: widening the mask raises irq at the write edge
    write_reg(2'd2, 32'h3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask_widen got=%0b exp=1", irq); end
    write_reg(2'd2, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_narrow got=%0b exp=0", irq); end
  endtask

  task automatic test_race();
    logic [31:0] d;
    btn = 5'h04;
    idle(6);
    // The rise of bit 2 lands in events at edge 7, together with this read
    addr  = 2'd1;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    $display("rd addr=1 data=0x%08h irq=%0b (race)", rdata, irq);
    checks++;
    if (rdata !== 32'h2) begin errors++; $display("FAIL race_old_flags got=0x%08h exp=0x00000002", rdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL race_irq got=%0b exp=0", irq); end
    read_reg(2'd1, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL race_new_flag got=0x%08h exp=0x00000004", d); end
    read_reg(2'd3, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL race_cnt got=0x%08h exp=0x00000004", d); end
    btn = 5'h00;
    idle(10);
  endtask

  task automatic test_rd_wr();
    logic [31:0] d;
    addr  = 2'd2;
    wdata = 32'h4;
    rd_en = 1'b1;
    wr_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    $display("rdwr addr=2 data=0x%08h", rdata);
    checks++;
    if (rdata !== 32'h1) begin errors++; $display("FAIL rdwr_old got=0x%08h exp=0x00000001", rdata); end
    read_reg(2'd2, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL rdwr_new got=0x%08h exp=0x00000004", d); end
    write_reg(2'd0, 32'h1F);
    read_reg(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ro_state_write got=0x%08h exp=0x00000000", d); end
    write_reg(2'd3, 32'hFF);
    read_reg(2'd3, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL ro_cnt_write got=0x%08h exp=0x00000004", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    read_reg(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wrap_cnt_reset got=0x%08h exp=0x00000000", d); end
    for (int i = 0; i < 255; i++) begin
      btn = 5'h01;
      idle(8);
      btn = 5'h00;
      idle(8);
    end
    read_reg(2'd3, d);
    checks++;
    if (d !== 32'hFF) begin errors++; $display("FAIL wrap_cnt_255 got=0x%08h exp=0x000000ff", d); end
    btn = 5'h03;
    idle(10);
    read_reg(2'd3, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL wrap_cnt_wrapped got=0x%08h exp=0x00000001", d); end
    read_reg(2'd1, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL wrap_events got=0x%08h exp=0x00000003", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq got=%0b exp=0", irq); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_glitch();
    test_interrupt();
    test_race();
    test_rd_wr();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
